fifo_traffic_gen: RTL and testbench
===================================

# fifo_traffic_gen

Synthesizable, self-checking traffic source for the synchronous FIFO. It drives the FIFO write/read ports that the verification monitor only observes. It generates an LFSR data stream, pushes and pops it under one of three traffic modes, and checks every wr_ack, data_out, overflow and underflow response in hardware. It sits on the FIFO's write/read interface in BIST wrappers and FPGA bring-up builds, and reports pass/fail plus error and correct counts.

## Interface
- DATA_WIDTH, 16, FIFO data width
- FIFO_DEPTH, 8, depth of the FIFO under test; sizes the probe fill
- NUM_WORDS, 64, words written and read per run in modes 0/1
- SEED, 16'hACE1, LFSR seed, nonzero
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begins a run when sampled high in IDLE
- mode  in  2  0 fill/drain, 1 mixed random, 2 overflow/underflow probe, 3 treated as 0
- wr_en  out  1  FIFO write request
- rd_en  out  1  FIFO read request
- data_in  out  DATA_WIDTH  FIFO write data
- data_out  in  DATA_WIDTH  FIFO read data, valid the cycle after rd_en
- wr_ack, overflow, underflow  in  1 each  FIFO registered responses, valid the cycle after the request
- full, empty  in  1 each  FIFO status flags for the current cycle
- busy  out  1  run in progress
- done  out  1  run finished; held until next start
- pass  out  1  done && error_count==0
- error_count  out  16  failed checks, saturating at 16'hFFFF
- correct_count  out  16  passed checks, saturating at 16'hFFFF

## Operation
- States: IDLE, FILL, DRAIN, MIX, PROBE_OVF, PROBE_UDF, FLUSH, DONE.
- IDLE / DONE + start: latch mode, clear counters and done, reload both LFSRs to SEED, set busy. Next state is FILL for modes 0 and 2, MIX for mode 1. start is ignored in any other state.
- Write LFSR (16-bit Galois, taps 16,14,13,11): its value, zero-extended or truncated to DATA_WIDTH, is driven on data_in. It advances on each legal write issue.
- Expect LFSR: same polynomial and seed; advances on each legal read issue.
- Legal write: wr_en=1 with full=0 and writes remaining. Legal read: rd_en=1 with empty=0 and reads remaining.
- Mode 0:
  - FILL writes every cycle until full=1 or all writes are issued, then goes to DRAIN.
  - DRAIN reads until empty=1 or all reads are issued, then goes back to FILL.
  - Once all NUM_WORDS are written and read, go to FLUSH.
- Mode 1 (MIX): each cycle, wr_en = LFSR bit 0 and legal; rd_en = LFSR bit 1 and legal. Reads and writes may be issued in the same cycle. After the NUM_WORDS count completes, go to FLUSH.
- Mode 2:
  - FILL writes FIFO_DEPTH words, then PROBE_OVF issues one wr_en with full=1. The write LFSR does not advance.
  - DRAIN reads FIFO_DEPTH words, then PROBE_UDF issues one rd_en with empty=1.
  - Then go to FLUSH.
- Checks, evaluated one cycle after the request; each increments exactly one of correct_count or error_count:
  - Legal write: wr_ack==1 and overflow==0.
  - Legal read: data_out == expect value and underflow==0.
  - Probe write: overflow==1 and wr_ack==0.
  - Probe read: underflow==1.
- FLUSH: one cycle to evaluate the final check, then go to DONE (busy=0, done=1).

## Timing
- Reset values: wr_en=0, rd_en=0, data_in=SEED[DATA_WIDTH-1:0], busy=0, done=0, pass=0, both counts 0, state IDLE.
- Reset mid-run aborts immediately and discards pending checks.
- start sampled at edge N; first wr_en at cycle N+1.
- Request at cycle N is checked at edge N+1.
- Mode 0 with FIFO_DEPTH=8 and NUM_WORDS=64: 8 write cycles alternate with 8 read cycles; done rises 130 cycles after start.
- Counters saturate and do not wrap.

## Configuration
- FIFO_TGEN_WATCHDOG_EN defined:
  - An 8-bit counter resets on any issued request.
  - After 256 consecutive cycles with no request while busy, increment error_count once and go to DONE.
- FIFO_TGEN_WATCHDOG_EN undefined: no watchdog. A stuck flag leaves busy=1 indefinitely.

## Test plan
- Mode 0, defaults, correct FIFO -> done=1, correct_count=128, error_count=0, pass=1.
- Mode 1, defaults -> correct_count=128, error_count=0, pass=1; at least one cycle with wr_en and rd_en both high.
- Mode 0, bench flips data_out[0] on the 3rd read response -> error_count=1, correct_count=127, pass=0.
- Mode 2, FIFO_DEPTH=8 -> overflow=1 seen after the 9th write request, underflow=1 after the 9th read request; correct_count=18, pass=1.
- rst pulsed for 1 cycle during FILL -> all outputs at reset values next cycle; a new start with mode 0 completes with pass=1.
- Mode 0 with full forced to 1 -> with FIFO_TGEN_WATCHDOG_EN: done=1 about 256 cycles after the last request, error_count ≥ 1. Without it: busy=1 after 1000 cycles.

Source files
------------

// File: rtl/fifo_traffic_gen.sv
// fifo_traffic_gen: LFSR traffic source for a synchronous FIFO that checks every response in hardware.
// Optional stall watchdog compiled in when FIFO_TGEN_WATCHDOG_EN is defined.
module fifo_traffic_gen #(
  parameter int          DATA_WIDTH = 16,
  parameter int          FIFO_DEPTH = 8,
  parameter int          NUM_WORDS  = 64,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic                  wr_ack,
  input  logic                  overflow,
  input  logic                  underflow,
  input  logic                  full,
  input  logic                  empty,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           error_count,
  output logic [15:0]           correct_count
);
  localparam int MAX_WORDS = (NUM_WORDS > FIFO_DEPTH) ? NUM_WORDS : FIFO_DEPTH;
  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0] ZERO    = '0;
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] WORDS_C = CW'(NUM_WORDS);
  localparam logic [15:0]   POLY    = 16'hB400;  // x^16 + x^14 + x^13 + x^11 + 1, right-shift Galois

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_DRAIN, S_MIX, S_PROBE_OVF, S_PROBE_UDF, S_FLUSH, S_DONE
  } state_t;

  state_t                state_reg, state_next;
  logic [1:0]            mode_reg;
  logic [15:0]           wr_lfsr_reg, rd_lfsr_reg, pat_lfsr_reg;
  logic [CW-1:0]         wr_left_reg, rd_left_reg, level_reg, level_next;
  logic                  chk_wr_reg, chk_rd_reg, chk_ovf_reg, chk_udf_reg;
  logic [DATA_WIDTH-1:0] exp_data_reg, wr_word, exp_word;
  logic [15:0]           error_count_reg, correct_count_reg;
  logic                  wr_ok, rd_ok, wr_issue, rd_issue, probe_wr, probe_rd;
  logic                  start_run, wdog_fire;
  logic [1:0]            ok_inc, err_inc;
  logic [CW-1:0]         run_words;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? POLY : 16'h0000);
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, c} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  generate
    if (DATA_WIDTH <= 16) begin : g_trunc
      assign wr_word  = wr_lfsr_reg[DATA_WIDTH-1:0];
      assign exp_word = rd_lfsr_reg[DATA_WIDTH-1:0];
    end else begin : g_zext
      assign wr_word  = {{(DATA_WIDTH-16){1'b0}}, wr_lfsr_reg};
      assign exp_word = {{(DATA_WIDTH-16){1'b0}}, rd_lfsr_reg};
    end
  endgenerate

  assign start_run = start && (state_reg == S_IDLE || state_reg == S_DONE);
  assign run_words = (mode == 2'd2) ? DEPTH_C : WORDS_C;
  assign wr_ok     = !full && (wr_left_reg != ZERO);
  assign rd_ok     = !empty && (rd_left_reg != ZERO);

  always_comb begin
    state_next = state_reg;
    wr_issue   = 1'b0;
    rd_issue   = 1'b0;
    probe_wr   = 1'b0;
    probe_rd   = 1'b0;
    case (state_reg)
      S_IDLE, S_DONE: if (start) state_next = (mode == 2'd1) ? S_MIX : S_FILL;
      S_FILL: begin
        wr_issue = wr_ok;
        if (mode_reg == 2'd2) begin
          if (wr_issue && wr_left_reg == ONE) state_next = S_PROBE_OVF;
        end else if (full || wr_left_reg == ZERO ||
                     (wr_issue && (level_reg + ONE == DEPTH_C || wr_left_reg == ONE))) begin
          // switching on the issuing cycle keeps fill and drain phases back to back
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        rd_issue = rd_ok;
        if (mode_reg == 2'd2) begin
          if (rd_issue && rd_left_reg == ONE) state_next = S_PROBE_UDF;
        end else if (rd_issue && rd_left_reg == ONE && wr_left_reg == ZERO) begin
          state_next = S_FLUSH;
        end else if (empty || rd_left_reg == ZERO || (rd_issue && level_reg == ONE)) begin
          state_next = S_FILL;
        end
      end
      S_MIX: begin
        wr_issue = pat_lfsr_reg[0] && wr_ok;
        rd_issue = pat_lfsr_reg[1] && rd_ok;
        if ((wr_left_reg == ZERO || (wr_issue && wr_left_reg == ONE)) &&
            (rd_left_reg == ZERO || (rd_issue && rd_left_reg == ONE)))
          state_next = S_FLUSH;
      end
      S_PROBE_OVF: begin
        probe_wr = full;
        if (full) state_next = S_DRAIN;
      end
      S_PROBE_UDF: begin
        probe_rd = empty;
        if (empty) state_next = S_FLUSH;
      end
      S_FLUSH: state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  assign wr_en      = wr_issue || probe_wr;
  assign rd_en      = rd_issue || probe_rd;
  assign data_in    = wr_word;
  assign level_next = level_reg + (wr_issue ? ONE : ZERO) - (rd_issue ? ONE : ZERO);

  // Responses land one cycle after the request; each pending check scores exactly once.
  always_comb begin
    ok_inc  = {1'b0, chk_wr_reg && wr_ack && !overflow}
            + {1'b0, chk_rd_reg && (data_out == exp_data_reg) && !underflow}
            + {1'b0, chk_ovf_reg && overflow && !wr_ack}
            + {1'b0, chk_udf_reg && underflow};
    err_inc = {1'b0, chk_wr_reg && !(wr_ack && !overflow)}
            + {1'b0, chk_rd_reg && !((data_out == exp_data_reg) && !underflow)}
            + {1'b0, chk_ovf_reg && !(overflow && !wr_ack)}
            + {1'b0, chk_udf_reg && !underflow}
            + {1'b0, wdog_fire};
  end

`ifdef FIFO_TGEN_WATCHDOG_EN
  logic [7:0] wdog_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          wdog_reg <= 8'd0;
    else if (!busy || wr_en || rd_en) wdog_reg <= 8'd0;
    else                              wdog_reg <= wdog_reg + 8'd1;
  end

  assign wdog_fire = busy && !wr_en && !rd_en && (wdog_reg == 8'hFF);
`else
  assign wdog_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= S_IDLE;
      mode_reg          <= 2'd0;
      wr_lfsr_reg       <= SEED;
      rd_lfsr_reg       <= SEED;
      pat_lfsr_reg      <= SEED;
      wr_left_reg       <= ZERO;
      rd_left_reg       <= ZERO;
      level_reg         <= ZERO;
      chk_wr_reg        <= 1'b0;
      chk_rd_reg        <= 1'b0;
      chk_ovf_reg       <= 1'b0;
      chk_udf_reg       <= 1'b0;
      exp_data_reg      <= '0;
      error_count_reg   <= 16'd0;
      correct_count_reg <= 16'd0;
    end else begin
      state_reg    <= wdog_fire ? S_DONE : state_next;
      chk_wr_reg   <= wr_issue;
      chk_rd_reg   <= rd_issue;
      chk_ovf_reg  <= probe_wr;
      chk_udf_reg  <= probe_rd;
      exp_data_reg <= exp_word;
      if (start_run) begin
        mode_reg          <= (mode == 2'd3) ? 2'd0 : mode;
        wr_lfsr_reg       <= SEED;
        rd_lfsr_reg       <= SEED;
        pat_lfsr_reg      <= SEED;
        wr_left_reg       <= run_words;
        rd_left_reg       <= run_words;
        level_reg         <= ZERO;
        error_count_reg   <= 16'd0;
        correct_count_reg <= 16'd0;
      end else begin
        error_count_reg   <= sat_add(error_count_reg, err_inc);
        correct_count_reg <= sat_add(correct_count_reg, ok_inc);
        level_reg         <= level_next;
        if (wr_issue) begin
          wr_lfsr_reg <= lfsr_step(wr_lfsr_reg);
          wr_left_reg <= wr_left_reg - ONE;
        end
        if (rd_issue) begin
          rd_lfsr_reg <= lfsr_step(rd_lfsr_reg);
          rd_left_reg <= rd_left_reg - ONE;
        end
        if (state_reg == S_MIX) pat_lfsr_reg <= lfsr_step(pat_lfsr_reg);
      end
    end
  end

  assign busy          = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign done          = (state_reg == S_DONE);
  assign pass          = done && (error_count_reg == 16'd0);
  assign error_count   = error_count_reg;
  assign correct_count = correct_count_reg;
endmodule

// File: tb/tb_fifo_traffic_gen.sv
// tb_fifo_traffic_gen: runs fifo_traffic_gen against a behavioural FIFO and scores each run.
`timescale 1ns/1ps
module tb_fifo_traffic_gen;
  localparam int          DW    = 16;
  localparam int          DEPTH = 8;
  localparam int          NW    = 64;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [1:0]    mode;
  logic          wr_en, rd_en, wr_ack, overflow, underflow, full, empty;
  logic [DW-1:0] data_in, data_out;
  logic          busy, done, pass;
  logic [15:0]   error_count, correct_count;

  always #5 clk = ~clk;

  fifo_traffic_gen #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .NUM_WORDS(NW), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in), .data_out(data_out),
    .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
    .full(full), .empty(empty), .busy(busy), .done(done), .pass(pass),
    .error_count(error_count), .correct_count(correct_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Behavioural FIFO with registered responses and optional fault injection.
  logic          force_full = 1'b0;
  logic          corrupt    = 1'b0;
  logic [DW-1:0] mem [DEPTH];
  int            wp, rp, cnt, rd_resp_n;

  assign full  = (cnt == DEPTH) || force_full;
  assign empty = (cnt == 0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= 0; rp <= 0; cnt <= 0; rd_resp_n <= 0;
      wr_ack <= 1'b0; overflow <= 1'b0; underflow <= 1'b0; data_out <= '0;
    end else begin
      wr_ack <= 1'b0; overflow <= 1'b0; underflow <= 1'b0;
      if (start) rd_resp_n <= 0;
      if (wr_en) begin
        if (!full) begin
          mem[wp] <= data_in;
          wp      <= (wp + 1) % DEPTH;
          wr_ack  <= 1'b1;
        end else overflow <= 1'b1;
      end
      if (rd_en) begin
        if (!empty) begin
          data_out  <= mem[rp] ^ DW'((corrupt && rd_resp_n == 2) ? 1 : 0);
          rp        <= (rp + 1) % DEPTH;
          rd_resp_n <= rd_resp_n + 1;
        end else underflow <= 1'b1;
      end
      cnt <= cnt + ((wr_en && !full) ? 1 : 0) - ((rd_en && !empty) ? 1 : 0);
    end
  end

  // Write-data monitor: each accepted write must carry the next value of the seeded LFSR.
  logic [15:0] model_lfsr = SEED;
  int          wr_req_n = 0, rd_req_n = 0, ovf_at = -1, udf_at = -1;
  bit          both_seen = 1'b0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic [15:0] s;
    s = v >> 1;
    if (v[0]) s = s ^ 16'hB400;
    return s;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (start) begin
        model_lfsr = SEED; wr_req_n = 0; rd_req_n = 0;
        ovf_at = -1; udf_at = -1; both_seen = 1'b0;
      end
      if (wr_en && rd_en) both_seen = 1'b1;
      if (wr_en) begin
        wr_req_n++;
        if (!full) begin
          check_val("wdata", data_in, model_lfsr);
          model_lfsr = lfsr_next(model_lfsr);
        end
      end
      if (rd_en) rd_req_n++;
      if (overflow && ovf_at < 0) ovf_at = wr_req_n;
      if (underflow && udf_at < 0) udf_at = rd_req_n;
    end
  end

  typedef struct {
    string name;
    int    correct;
    int    errors;
    bit    pass_v;
  } run_exp_t;
  run_exp_t exp_q[$];

  // Pulse start, then count posedges from the start assertion until done is seen.
  task automatic launch_wait(input logic [1:0] m, input int budget, output int cyc, output bit ok);
    ok = 1'b0;
    @(negedge clk); #1 mode = m; start = 1'b1;
    @(posedge clk); cyc = 1;
    @(negedge clk); #1 start = 1'b0;
    while (cyc < budget) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic run_mode(input string name, input logic [1:0] m, input int exp_c,
                          input int exp_e, input bit exp_p, output int cyc);
    run_exp_t e;
    bit ok;
    e.name = name; e.correct = exp_c; e.errors = exp_e; e.pass_v = exp_p;
    exp_q.push_back(e);
    launch_wait(m, 2000, cyc, ok);
    check_val({name, "_done"}, ok, 1);
    e = exp_q.pop_front();
    check_val({e.name, "_correct"}, correct_count, e.correct);
    check_val({e.name, "_errors"}, error_count, e.errors);
    check_val({e.name, "_pass"}, pass, e.pass_v);
    $display("run %s: mode=%0d cycles=%0d correct=%0d errors=%0d pass=%0b",
             name, m, cyc, correct_count, error_count, pass);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_wr_en"}, wr_en, 0);
    check_val({pfx, "_rd_en"}, rd_en, 0);
    check_val({pfx, "_data_in"}, data_in, SEED);
    check_val({pfx, "_busy"}, busy, 0);
    check_val({pfx, "_done"}, done, 0);
    check_val({pfx, "_pass"}, pass, 0);
    check_val({pfx, "_errors"}, error_count, 0);
    check_val({pfx, "_correct"}, correct_count, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "time limit");
  end

  initial begin
    int  cyc;
    bit  ok;
    rst = 1'b1; start = 1'b0; mode = 2'd0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    run_mode("m0", 2'd0, 2 * NW, 0, 1'b1, cyc);
    check_val("m0_latency", cyc, 130);

    run_mode("m1", 2'd1, 2 * NW, 0, 1'b1, cyc);
    check_val("m1_both_seen", both_seen, 1);

    corrupt = 1'b1;
    run_mode("m0_corrupt", 2'd0, 2 * NW - 1, 1, 1'b0, cyc);
    corrupt = 1'b0;

    run_mode("m2", 2'd2, 2 * DEPTH + 2, 0, 1'b1, cyc);
    check_val("m2_ovf_at", ovf_at, DEPTH + 1);
    check_val("m2_udf_at", udf_at, DEPTH + 1);

    run_mode("m3", 2'd3, 2 * NW, 0, 1'b1, cyc);

    // Abort a mode-0 run during its fill phase.
    @(negedge clk); #1 mode = 2'd0; start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check_val("midrun_busy", busy, 1);
    #1 rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrun_rst");
    #1 rst = 1'b0;
    @(negedge clk);
    run_mode("m0_after_rst", 2'd0, 2 * NW, 0, 1'b1, cyc);

    force_full = 1'b1;
`ifdef FIFO_TGEN_WATCHDOG_EN
    launch_wait(2'd0, 400, cyc, ok);
    check_val("wdog_done", ok, 1);
    check_val("wdog_errors", error_count, 1);
    check_val("wdog_pass", pass, 0);
    $display("run stuck_full: cycles=%0d errors=%0d", cyc, error_count);
`else
    launch_wait(2'd0, 1000, cyc, ok);
    check_val("stuck_no_done", ok, 0);
    check_val("stuck_busy", busy, 1);
    $display("run stuck_full: cycles=%0d busy=%0b", cyc, busy);
`endif
    force_full = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
